// File: rtl/fast_corner_engine_if.sv
// Pixel read port and classification write port shared by the FAST engine and its SRAMs.
interface fast_corner_engine_if #(
    parameter int unsigned AW    = 7,
    parameter int unsigned PIX_W = 8
);
    logic             rd_req;
    logic [AW-1:0]    rd_x;
    logic [AW-1:0]    rd_y;
    logic [PIX_W-1:0] rd_data;
    logic             rd_valid;
    logic             wr_en;
    logic [AW-1:0]    wr_x;
    logic [AW-1:0]    wr_y;
    logic [1:0]       wr_data;

    modport master (
        output rd_req, rd_x, rd_y,
        input  rd_data, rd_valid,
        output wr_en, wr_x, wr_y, wr_data
    );

    modport slave (
        input  rd_req, rd_x, rd_y,
        output rd_data, rd_valid,
        input  wr_en, wr_x, wr_y, wr_data
    );
endinterface

// File: rtl/fast_corner_engine.sv
// FAST-N corner detector: raster-scans a frame through a single-outstanding read port and
// writes a 2-bit class (00 none, 01 bright, 10 dark) for every pixel.
module fast_corner_engine #(
    parameter int unsigned X_MAX = 64,
    parameter int unsigned Y_MAX = 64,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic [$clog2(X_MAX)-1:0] max_x,
    input  logic [$clog2(Y_MAX)-1:0] max_y,
    input  logic [PIX_W-1:0]         threshold,
    input  logic [4:0]               arc_len,
    fast_corner_engine_if.master     bus,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         corner_count
);
    localparam int unsigned XW = $clog2(X_MAX);
    localparam int unsigned YW = $clog2(Y_MAX);
    localparam int unsigned AW = XW + 1;
    localparam logic [XW:0] X_THREE = 3;
    localparam logic [YW:0] Y_THREE = 3;

    typedef enum logic [2:0] {StIdle, StLoadC, StLoadR, StEval, StWrite, StDone} state_e;

    state_e             state_q, state_d;
    logic [XW-1:0]      x_q, x_d, max_x_q, max_x_d, nx;
    logic [YW-1:0]      y_q, y_d, max_y_q, max_y_d, ny;
    logic [PIX_W-1:0]   thr_q, thr_d, c_q, c_d;
    logic [4:0]         arc_q, arc_d;
    logic [15:0]        bright_q, bright_d, dark_q, dark_d;
    logic [3:0]         idx_q, idx_d;
    logic               pending_q, pending_d;
    logic               rd_req_q, rd_req_d;
    logic [AW-1:0]      rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    logic               wr_en_q, wr_en_d;
    logic [AW-1:0]      wr_x_q, wr_x_d, wr_y_q, wr_y_d;
    logic [1:0]         wr_data_q, wr_data_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               nxt_interior;
    logic [5:0]         ring_nxt;

    // Ring offsets as {dx, dy}, each 3-bit two's complement.
    function automatic logic [5:0] ring_off(input logic [3:0] idx);
        case (idx)
            4'd0:    ring_off = 6'b000_101;
            4'd1:    ring_off = 6'b001_101;
            4'd2:    ring_off = 6'b010_110;
            4'd3:    ring_off = 6'b011_111;
            4'd4:    ring_off = 6'b011_000;
            4'd5:    ring_off = 6'b011_001;
            4'd6:    ring_off = 6'b010_010;
            4'd7:    ring_off = 6'b001_011;
            4'd8:    ring_off = 6'b000_011;
            4'd9:    ring_off = 6'b111_011;
            4'd10:   ring_off = 6'b110_010;
            4'd11:   ring_off = 6'b101_001;
            4'd12:   ring_off = 6'b101_000;
            4'd13:   ring_off = 6'b101_111;
            4'd14:   ring_off = 6'b110_110;
            default: ring_off = 6'b111_101;
        endcase
    endfunction

    function automatic logic [AW-1:0] add_off(input logic [AW-1:0] base, input logic [2:0] off);
        return base + {{(AW-3){off[2]}}, off};
    endfunction

    // True when some circular window of n ring bits is all set.
    function automatic logic has_arc(input logic [15:0] bits, input logic [4:0] n);
        logic       found;
        logic       ok;
        logic [3:0] j;
        found = 1'b0;
        for (int s = 0; s < 16; s++) begin
            ok = 1'b1;
            for (int k = 0; k < 16; k++) begin
                j = 4'(s + k);
                if ((k < int'(n)) && !bits[j]) ok = 1'b0;
            end
            found = found | ok;
        end
        return found;
    endfunction

    // Ring pixel compare in PIX_W+2-bit signed arithmetic so c+t and c-t never wrap.
    logic signed [PIX_W+1:0] p_s, c_s, t_s;
    logic                    ring_bright, ring_dark;
    assign p_s         = $signed({2'b00, bus.rd_data});
    assign c_s         = $signed({2'b00, c_q});
    assign t_s         = $signed({2'b00, thr_q});
    assign ring_bright = p_s > (c_s + t_s);
    assign ring_dark   = p_s < (c_s - t_s);

    // Next-state, read/write sequencing and corner counting.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        max_x_d   = max_x_q;
        max_y_d   = max_y_q;
        thr_d     = thr_q;
        arc_d     = arc_q;
        c_d       = c_q;
        bright_d  = bright_q;
        dark_d    = dark_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        rd_req_d  = 1'b0;
        rd_x_d    = rd_x_q;
        rd_y_d    = rd_y_q;
        wr_en_d   = 1'b0;
        wr_x_d    = wr_x_q;
        wr_y_d    = wr_y_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;

        if (x_q == max_x_q) begin
            nx = '0;
            ny = y_q + 1'b1;
        end else begin
            nx = x_q + 1'b1;
            ny = y_q;
        end
        nxt_interior = ({1'b0, nx} >= X_THREE) && (({1'b0, nx} + X_THREE) <= {1'b0, max_x_q}) &&
                       ({1'b0, ny} >= Y_THREE) && (({1'b0, ny} + Y_THREE) <= {1'b0, max_y_q});
        ring_nxt = ring_off((state_q == StLoadR) ? idx_q + 4'd1 : 4'd0);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    max_x_d = max_x;
                    max_y_d = max_y;
                    thr_d   = threshold;
                    arc_d   = (arc_len < 5'd9) ? 5'd9 : (arc_len > 5'd16) ? 5'd16 : arc_len;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    // (0,0) is never interior, so the frame always opens with a border write
                    state_d   = StWrite;
                    wr_en_d   = 1'b1;
                    wr_x_d    = '0;
                    wr_y_d    = '0;
                    wr_data_d = 2'b00;
                end
            end
            StLoadC: begin
                if (pending_q && bus.rd_valid) begin
                    c_d      = bus.rd_data;
                    idx_d    = '0;
                    state_d  = StLoadR;
                    rd_req_d = 1'b1;
                    rd_x_d   = add_off(AW'(x_q), ring_nxt[5:3]);
                    rd_y_d   = add_off(AW'(y_q), ring_nxt[2:0]);
                end
            end
            StLoadR: begin
                if (pending_q && bus.rd_valid) begin
                    bright_d[idx_q] = ring_bright;
                    dark_d[idx_q]   = ring_dark;
                    if (idx_q == 4'd15) begin
                        pending_d = 1'b0;
                        state_d   = StEval;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        rd_req_d = 1'b1;
                        rd_x_d   = add_off(AW'(x_q), ring_nxt[5:3]);
                        rd_y_d   = add_off(AW'(y_q), ring_nxt[2:0]);
                    end
                end
            end
            StEval: begin
                state_d = StWrite;
                wr_en_d = 1'b1;
                wr_x_d  = AW'(x_q);
                wr_y_d  = AW'(y_q);
                // Bright wins if both arcs qualify
                if (has_arc(bright_q, arc_q))    wr_data_d = 2'b01;
                else if (has_arc(dark_q, arc_q)) wr_data_d = 2'b10;
                else                             wr_data_d = 2'b00;
            end
            StWrite: begin
                if ((wr_data_q != 2'b00) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
                if ((x_q == max_x_q) && (y_q == max_y_q)) begin
                    state_d = StDone;
                end else begin
                    x_d = nx;
                    y_d = ny;
                    if (nxt_interior) begin
                        state_d   = StLoadC;
                        rd_req_d  = 1'b1;
                        pending_d = 1'b1;
                        rd_x_d    = AW'(nx);
                        rd_y_d    = AW'(ny);
                    end else begin
                        state_d   = StWrite;
                        wr_en_d   = 1'b1;
                        wr_x_d    = AW'(nx);
                        wr_y_d    = AW'(ny);
                        wr_data_d = 2'b00;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle) && (state_d != StDone);
        done_d = (state_d == StDone);
    end

    // State and registered outputs; reset aborts any frame and drops pending reads.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            max_x_q   <= '0;
            max_y_q   <= '0;
            thr_q     <= '0;
            arc_q     <= '0;
            c_q       <= '0;
            bright_q  <= '0;
            dark_q    <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_x_q    <= '0;
            rd_y_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            max_x_q   <= max_x_d;
            max_y_q   <= max_y_d;
            thr_q     <= thr_d;
            arc_q     <= arc_d;
            c_q       <= c_d;
            bright_q  <= bright_d;
            dark_q    <= dark_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            rd_req_q  <= rd_req_d;
            rd_x_q    <= rd_x_d;
            rd_y_q    <= rd_y_d;
            wr_en_q   <= wr_en_d;
            wr_x_q    <= wr_x_d;
            wr_y_q    <= wr_y_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.rd_req   = rd_req_q;
    assign bus.rd_x     = rd_x_q;
    assign bus.rd_y     = rd_y_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_x     = wr_x_q;
    assign bus.wr_y     = wr_y_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign corner_count = cnt_q;
endmodule

// File: tb/tb_fast_corner_engine.sv
// Scoreboard bench for fast_corner_engine: stimulus pushes expected writes, a monitor pops them.
module tb_fast_corner_engine;
    localparam int unsigned X_MAX = 64;
    localparam int unsigned Y_MAX = 64;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned AW    = $clog2(X_MAX) + 1;

    typedef struct {
        int         x;
        int         y;
        logic [1:0] d;
    } wr_t;

    logic                     clk = 1'b0;
    logic                     n_rst = 1'b0;
    logic                     start = 1'b0;
    logic [$clog2(X_MAX)-1:0] max_x = '0;
    logic [$clog2(Y_MAX)-1:0] max_y = '0;
    logic [PIX_W-1:0]         threshold = '0;
    logic [4:0]               arc_len = '0;
    logic                     busy;
    logic                     done;
    logic [CNT_W-1:0]         corner_count;

    fast_corner_engine_if #(.AW(AW), .PIX_W(PIX_W)) bus ();

    fast_corner_engine #(
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX),
        .PIX_W(PIX_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .max_x(max_x),
        .max_y(max_y),
        .threshold(threshold),
        .arc_len(arc_len),
        .bus(bus),
        .busy(busy),
        .done(done),
        .corner_count(corner_count)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  n_reads = 0;
    int  n_writes = 0;
    int  lat_fixed = 1;
    wr_t exp_q[$];
    wr_t got_e;
    logic [7:0] img [0:7][0:7];
    int  dx_tab [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int  dy_tab [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
    int  rsp_lat, rsp_x, rsp_y;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Memory responder: one read in flight, data returned rsp_lat cycles after rd_req.
    initial begin
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.rd_req) begin
                rsp_lat = (lat_fixed == 0) ? int'($urandom_range(4, 1)) : lat_fixed;
                rsp_x   = int'(bus.rd_x);
                rsp_y   = int'(bus.rd_y);
                repeat (rsp_lat) @(posedge clk);
                #1;
                bus.rd_valid = 1'b1;
                bus.rd_data  = (rsp_x < 8 && rsp_y < 8) ? img[rsp_y][rsp_x] : 8'hEE;
                @(posedge clk);
                #1;
                bus.rd_valid = 1'b0;
            end
        end
    end

    // Monitor: every write strobe is checked against the head of the expected queue.
    always @(negedge clk) begin
        if (bus.rd_req) n_reads++;
        if (bus.wr_en) begin
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got (%0d,%0d)=%0d, required no write",
                         bus.wr_x, bus.wr_y, bus.wr_data);
            end else begin
                got_e = exp_q.pop_front();
                if (int'(bus.wr_x) != got_e.x || int'(bus.wr_y) != got_e.y ||
                    bus.wr_data !== got_e.d) begin
                    errors++;
                    $display("FAIL write: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d",
                             bus.wr_x, bus.wr_y, bus.wr_data, got_e.x, got_e.y, got_e.d);
                end
            end
        end
    end

    // Image with centre c at (3,3); all ring pixels = base, then cnt of them from first = hi.
    task automatic set_ring(input int c, input int base, input int hi, input int first,
                            input int cnt);
        int j;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) img[y][x] = 8'd0;
        img[3][3] = 8'(c);
        for (int i = 0; i < 16; i++) img[3 + dy_tab[i]][3 + dx_tab[i]] = 8'(base);
        for (int i = 0; i < cnt; i++) begin
            j = (first + i) % 16;
            img[3 + dy_tab[j]][3 + dx_tab[j]] = 8'(hi);
        end
    endtask

    task automatic push_frame(input int mx, input int my, input logic [1:0] exp_c,
                              output int exp_reads);
        wr_t w;
        bit  inner;
        exp_reads = 0;
        for (int y = 0; y <= my; y++) begin
            for (int x = 0; x <= mx; x++) begin
                inner = (x >= 3) && (x <= mx - 3) && (y >= 3) && (y <= my - 3);
                w.x = x;
                w.y = y;
                w.d = inner ? exp_c : 2'b00;
                if (inner) exp_reads += 17;
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic pulse_start(input int mx, input int my, input int t, input int n);
        @(negedge clk);
        n_reads   = 0;
        n_writes  = 0;
        max_x     = 6'(mx);
        max_y     = 6'(my);
        threshold = 8'(t);
        arc_len   = 5'(n);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input string name, input int mx, input int my, input int t,
                             input int n, input logic [1:0] exp_c, input int exp_count,
                             input bit poke, input bit done_start);
        int exp_reads;
        int nw;
        bit seen;
        push_frame(mx, my, exp_c, exp_reads);
        pulse_start(mx, my, t, n);
        check({name, "_busy_rise"}, busy, 1);
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            if (poke && i == 20) begin
                start     = 1'b1;
                threshold = 8'd255;
                arc_len   = 5'd16;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        start     = 1'b0;
        threshold = 8'(t);
        arc_len   = 5'(n);
        check({name, "_done_seen"}, seen, 1);
        if (!seen) begin
            exp_q.delete();
            n_rst = 1'b0;
            repeat (2) @(negedge clk);
            n_rst = 1'b1;
            return;
        end
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_count"}, corner_count, exp_count);
        check({name, "_reads"}, n_reads, exp_reads);
        check({name, "_writes"}, n_writes, (mx + 1) * (my + 1));
        check({name, "_queue_left"}, exp_q.size(), 0);
        if (done_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_done_one_cycle"}, done, 0);
        if (done_start) begin
            nw = n_writes;
            repeat (10) @(negedge clk);
            check({name, "_start_in_done_ignored"}, n_writes, nw);
            check({name, "_idle_after_done"}, busy, 0);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rd_req"}, bus.rd_req, 0);
        check({name, "_rd_x"}, bus.rd_x, 0);
        check({name, "_rd_y"}, bus.rd_y, 0);
        check({name, "_wr_en"}, bus.wr_en, 0);
        check({name, "_wr_x"}, bus.wr_x, 0);
        check({name, "_wr_y"}, bus.wr_y, 0);
        check({name, "_wr_data"}, bus.wr_data, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_count"}, corner_count, 0);
    endtask

    task automatic reset_midframe(input string name, input int wait_reads, input int wait_writes,
                                  input int cnt_before);
        int  dummy;
        int  nw;
        int  nr;
        bit  reached;
        push_frame(6, 6, 2'b01, dummy);
        pulse_start(6, 6, 20, 9);
        reached = 1'b0;
        for (int i = 0; i < 5000 && !reached; i++) begin
            @(negedge clk);
            if (n_reads >= wait_reads && n_writes >= wait_writes) reached = 1'b1;
        end
        check({name, "_reached"}, reached, 1);
        check({name, "_count_before"}, corner_count, cnt_before);
        n_rst = 1'b0;
        #1;
        check_all_zero(name);
        exp_q.delete();
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        nw = n_writes;
        nr = n_reads;
        repeat (10) @(negedge clk);
        check({name, "_no_writes_after"}, n_writes, nw);
        check({name, "_no_reads_after"}, n_reads, nr);
        check({name, "_idle_after"}, busy, 0);
    endtask

    initial begin
        set_ring(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);

        lat_fixed = 1;
        run_frame("flat", 6, 6, 20, 9, 2'b00, 0, 1'b0, 1'b0);
        set_ring(100, 100, 130, 0, 9);
        run_frame("bright_n9", 6, 6, 20, 9, 2'b01, 1, 1'b0, 1'b0);
        run_frame("bright_n12", 6, 6, 20, 12, 2'b00, 0, 1'b0, 1'b0);

        lat_fixed = 2;
        set_ring(100, 100, 130, 12, 9);
        run_frame("wrap9", 6, 6, 20, 9, 2'b01, 1, 1'b0, 1'b0);
        set_ring(100, 100, 130, 0, 8);
        run_frame("run8", 6, 6, 20, 9, 2'b00, 0, 1'b0, 1'b0);
        set_ring(100, 79, 79, 0, 0);
        run_frame("dark79", 6, 6, 20, 9, 2'b10, 1, 1'b0, 1'b0);
        set_ring(100, 80, 80, 0, 0);
        run_frame("dark80_strict", 6, 6, 20, 9, 2'b00, 0, 1'b0, 1'b0);
        set_ring(100, 120, 120, 0, 0);
        run_frame("bright120_strict", 6, 6, 20, 9, 2'b00, 0, 1'b0, 1'b0);

        lat_fixed = 3;
        set_ring(100, 100, 130, 0, 9);
        run_frame("clamp_lo_9", 6, 6, 20, 5, 2'b01, 1, 1'b0, 1'b0);
        set_ring(100, 100, 130, 3, 8);
        run_frame("clamp_lo_8", 6, 6, 20, 5, 2'b00, 0, 1'b0, 1'b0);
        set_ring(100, 130, 130, 0, 0);
        run_frame("clamp_hi_16", 6, 6, 20, 20, 2'b01, 1, 1'b0, 1'b0);
        set_ring(100, 100, 130, 0, 15);
        run_frame("clamp_hi_15", 6, 6, 20, 20, 2'b00, 0, 1'b0, 1'b0);
        run_frame("small", 4, 4, 20, 9, 2'b00, 0, 1'b0, 1'b0);

        set_ring(100, 100, 130, 0, 9);
        run_frame("start_busy", 6, 6, 20, 9, 2'b01, 1, 1'b1, 1'b1);

        lat_fixed = 4;
        reset_midframe("rst_reads", 5, 0, 0);
        run_frame("after_rst_reads", 6, 6, 20, 9, 2'b01, 1, 1'b0, 1'b0);
        reset_midframe("rst_tail", 17, 27, 1);
        run_frame("after_rst_tail", 6, 6, 20, 9, 2'b01, 1, 1'b0, 1'b0);

        lat_fixed = 0;
        run_frame("rand_bright", 6, 6, 20, 9, 2'b01, 1, 1'b0, 1'b0);
        set_ring(100, 100, 130, 12, 9);
        run_frame("rand_wrap", 6, 6, 20, 9, 2'b01, 1, 1'b0, 1'b0);
        set_ring(100, 79, 79, 0, 0);
        run_frame("rand_dark", 6, 6, 20, 9, 2'b10, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
